// File: rtl/adder_bist_ctrl.sv
// adder_bist_ctrl: built-in self-test sequencer for a 16-bit adder.
// Drives 8 directed vectors followed by NUM_RANDOM LFSR vectors, holds each
// for SETTLE_CYCLES+1 cycles, checks the 17-bit result against a reference
// and reports error count, first failing index and pass/done status.
module adder_bist_ctrl #(
  parameter int          NUM_RANDOM    = 64,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] SEED          = 32'hACE1_1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] sum,
  input  logic        overflow,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] first_fail_idx,
  output logic        fail_seen
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [15:0] LP_SETTLE = 16'(SETTLE_CYCLES);
  localparam logic [16:0] LP_LAST   = 17'(7 + NUM_RANDOM);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_cin;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [7:0]  r_err;
  logic [15:0] r_ffi;
  logic        r_fail;
  logic [16:0] r_vec_idx;
  logic [15:0] r_settle;
  logic [31:0] r_lfsr;

  logic        w_load0;
  logic        w_sample;
  logic        w_last;
  logic        w_mismatch;
  logic [16:0] w_ref;
  logic [16:0] w_next_idx;
  logic [31:0] w_lfsr_nxt;

  // Directed vector table, packed as {carry_in, b, a}.
  function automatic logic [32:0] f_directed(input logic [2:0] idx);
    logic [32:0] v;
    case (idx)
      3'd0:    v = {1'b0, 16'h0000, 16'h0000};
      3'd1:    v = {1'b0, 16'h0001, 16'hFFFF};
      3'd2:    v = {1'b0, 16'hFFFF, 16'hFFFF};
      3'd3:    v = {1'b1, 16'h5555, 16'hAAAA};
      3'd4:    v = {1'b0, 16'h5555, 16'hAAAA};
      3'd5:    v = {1'b0, 16'h0002, 16'hFFFF};
      3'd6:    v = {1'b1, 16'h00FF, 16'h00FF};
      default: v = {1'b0, 16'h00FF, 16'h00FF};
    endcase
    return v;
  endfunction

  // Fibonacci LFSR, taps 32,22,2,1, shifting left with feedback into bit 0.
  function automatic logic [31:0] f_lfsr_step(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  assign w_ref      = {1'b0, r_a} + {1'b0, r_b} + {16'd0, r_cin};
  assign w_mismatch = ({overflow, sum} != w_ref);
  assign w_sample   = (r_state == S_RUN) && (r_settle == LP_SETTLE);
  assign w_last     = (r_vec_idx == LP_LAST);
  assign w_next_idx = r_vec_idx + 17'd1;
  assign w_lfsr_nxt = f_lfsr_step(r_lfsr);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; start is only honored outside RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_load0     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_load0     = 1'b1;
        end
      end
      S_RUN: begin
        if (w_sample && w_last) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Vector sequencing, result checking and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= 16'd0;
      r_b       <= 16'd0;
      r_cin     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= 8'd0;
      r_ffi     <= 16'd0;
      r_fail    <= 1'b0;
      r_vec_idx <= 17'd0;
      r_settle  <= 16'd0;
      r_lfsr    <= SEED;
    end else if (w_load0) begin
      {r_cin, r_b, r_a} <= f_directed(3'd0);
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= 8'd0;
      r_ffi     <= 16'd0;
      r_fail    <= 1'b0;
      r_vec_idx <= 17'd0;
      r_settle  <= 16'd0;
      r_lfsr    <= SEED;
    end else if (r_state == S_RUN) begin
      if (!w_sample) begin
        r_settle <= r_settle + 16'd1;
      end else begin
        if (w_mismatch) begin
          if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          if (!r_fail) begin
            r_ffi  <= r_vec_idx[15:0];
            r_fail <= 1'b1;
          end
        end
        if (w_last) begin
          // Operands are left holding the final vector.
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_pass <= !(r_fail || w_mismatch);
        end else begin
          r_vec_idx <= w_next_idx;
          r_settle  <= 16'd0;
          if (w_next_idx < 17'd8) begin
            {r_cin, r_b, r_a} <= f_directed(w_next_idx[2:0]);
          end else begin
            // The LFSR advances on the edge that loads each random vector.
            r_lfsr <= w_lfsr_nxt;
            r_a    <= w_lfsr_nxt[15:0];
            r_b    <= w_lfsr_nxt[31:16];
            r_cin  <= w_lfsr_nxt[0] ^ w_lfsr_nxt[31];
          end
        end
      end
    end
  end

  assign a              = r_a;
  assign b              = r_b;
  assign carry_in       = r_cin;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_fail_idx = r_ffi;
  assign fail_seen      = r_fail;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// tb_adder_bist_ctrl: directed bench for adder_bist_ctrl. Three instances
// (NUM_RANDOM = 0, default 64, 300) each see a behavioural adder that can be
// switched to a faulty mode.
module tb_adder_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  int   fault = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [15:0] a0, b0, s0, ffi0, a1, b1, s1, ffi1, a2, b2, s2, ffi2;
  logic        c0, ov0, busy0, done0, pass0, fs0;
  logic        c1, ov1, busy1, done1, pass1, fs1;
  logic        c2, ov2, busy2, done2, pass2, fs2;
  logic [7:0]  err0, err1, err2;

  logic [15:0] ta[8];
  logic [15:0] tbv[8];
  logic        tc[8];

  localparam logic [31:0] SEED = 32'hACE1_1234;

  always #5 clk = ~clk;

  // Behavioural adder: mode 1 forces overflow to 0, mode 2 inverts sum.
  function automatic logic [16:0] adder(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input int mode);
    logic [16:0] r;
    r = {1'b0, x} + {1'b0, y} + {16'd0, c};
    if (mode == 1) r[16] = 1'b0;
    else if (mode == 2) r[15:0] = ~r[15:0];
    return r;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    logic fb;
    fb = x[31] ^ x[21] ^ x[1] ^ x[0];
    return {x[30:0], fb};
  endfunction

  assign {ov0, s0} = adder(a0, b0, c0, fault);
  assign {ov1, s1} = adder(a1, b1, c1, fault);
  assign {ov2, s2} = adder(a2, b2, c2, fault);

  adder_bist_ctrl #(.NUM_RANDOM(0), .SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .sum(s0), .overflow(ov0),
    .a(a0), .b(b0), .carry_in(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_idx(ffi0), .fail_seen(fs0));

  adder_bist_ctrl dut1 (
    .clk(clk), .rst(rst), .start(start1), .sum(s1), .overflow(ov1),
    .a(a1), .b(b1), .carry_in(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_idx(ffi1), .fail_seen(fs1));

  adder_bist_ctrl #(.NUM_RANDOM(300)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sum(s2), .overflow(ov2),
    .a(a2), .b(b2), .carry_in(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_idx(ffi2), .fail_seen(fs2));

  // Status packed as {busy, done, pass, fail_seen, err_count, first_fail_idx}.
  wire [27:0] st0 = {busy0, done0, pass0, fs0, err0, ffi0};
  wire [27:0] st1 = {busy1, done1, pass1, fs1, err1, ffi1};
  wire [27:0] st2 = {busy2, done2, pass2, fs2, err2, ffi2};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start0 = 1'b1;
    else if (which == 1) start1 = 1'b1;
    else start2 = 1'b1;
    tick(1);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n_vec++;
    if ({a0, b0, c0, st0} !== 61'd0) begin
      $display("FAIL reset_dut0 got %h expected 0", {a0, b0, c0, st0}); n_bad++;
    end
    n_vec++;
    if ({a1, b1, c1, st1} !== 61'd0) begin
      $display("FAIL reset_dut1 got %h expected 0", {a1, b1, c1, st1}); n_bad++;
    end
    n_vec++;
    if ({a2, b2, c2, st2} !== 61'd0) begin
      $display("FAIL reset_dut2 got %h expected 0", {a2, b2, c2, st2}); n_bad++;
    end
  endtask

  task automatic test_directed();
    fault = 0;
    pulse_start(0);
    for (int n = 0; n < 8; n++) begin
      n_vec++;
      if ({a0, b0, c0} !== {ta[n], tbv[n], tc[n]}) begin
        $display("FAIL dir_vec%0d got %h expected %h", n, {a0, b0, c0}, {ta[n], tbv[n], tc[n]});
        n_bad++;
      end
      n_vec++;
      if ({busy0, done0} !== 2'b10) begin
        $display("FAIL dir_busy%0d got %b expected 10", n, {busy0, done0}); n_bad++;
      end
      tick(3);
    end
    n_vec++;
    if (st0 !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 16'd0}) begin
      $display("FAIL dir_done got %h expected %h", st0, {4'b0110, 24'd0}); n_bad++;
    end
    n_vec++;
    if ({a0, b0, c0} !== {16'h00FF, 16'h00FF, 1'b0}) begin
      $display("FAIL dir_hold got %h expected %h", {a0, b0, c0}, {16'h00FF, 16'h00FF, 1'b0});
      n_bad++;
    end
  endtask

  task automatic test_ovf_stuck();
    fault = 1;
    pulse_start(0);
    n_vec++;
    if (st0 !== {4'b1000, 24'd0}) begin
      $display("FAIL ovf_start got %h expected %h", st0, {4'b1000, 24'd0}); n_bad++;
    end
    tick(23);
    n_vec++;
    if (done0 !== 1'b0) begin
      $display("FAIL ovf_early_done got %b expected 0", done0); n_bad++;
    end
    tick(1);
    n_vec++;
    if (st0 !== {1'b0, 1'b1, 1'b0, 1'b1, 8'd4, 16'd1}) begin
      $display("FAIL ovf_result got %h expected %h", st0, {4'b0101, 8'd4, 16'd1}); n_bad++;
    end
  endtask

  task automatic test_saturate();
    fault = 2;
    pulse_start(2);
    tick(923);
    n_vec++;
    if (done2 !== 1'b0) begin
      $display("FAIL sat_early_done got %b expected 0", done2); n_bad++;
    end
    tick(1);
    n_vec++;
    if (st2 !== {1'b0, 1'b1, 1'b0, 1'b1, 8'd255, 16'd0}) begin
      $display("FAIL sat_result got %h expected %h", st2, {4'b0101, 8'd255, 16'd0}); n_bad++;
    end
  endtask

  task automatic test_random();
    logic [31:0] lf;
    logic [32:0] exp_v;
    fault = 0;
    lf = SEED;
    pulse_start(1);
    for (int n = 0; n < 72; n++) begin
      if (n < 8) begin
        exp_v = {tc[n], tbv[n], ta[n]};
      end else begin
        lf = lfsr_step(lf);
        exp_v = {lf[0] ^ lf[31], lf[31:16], lf[15:0]};
      end
      n_vec++;
      if ({c1, b1, a1} !== exp_v) begin
        $display("FAIL rnd_vec%0d got %h expected %h", n, {c1, b1, a1}, exp_v); n_bad++;
      end
      tick(3);
    end
    n_vec++;
    if (st1 !== {4'b0110, 24'd0}) begin
      $display("FAIL rnd_done got %h expected %h", st1, {4'b0110, 24'd0}); n_bad++;
    end
  endtask

  task automatic test_rst_mid();
    fault = 1;
    pulse_start(0);
    tick(15);
    n_vec++;
    if ({a0, b0, err0} !== {16'hFFFF, 16'h0002, 8'd3}) begin
      $display("FAIL rstmid_pre got %h expected %h", {a0, b0, err0}, {16'hFFFF, 16'h0002, 8'd3});
      n_bad++;
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_vec++;
    if ({a0, b0, c0, st0} !== 61'd0) begin
      $display("FAIL rstmid_clear got %h expected 0", {a0, b0, c0, st0}); n_bad++;
    end
    tick(3);
    n_vec++;
    if ({a0, b0, c0, st0} !== 61'd0) begin
      $display("FAIL rstmid_idle got %h expected 0", {a0, b0, c0, st0}); n_bad++;
    end
    fault = 0;
    pulse_start(0);
    n_vec++;
    if ({a0, b0, c0, st0} !== {33'd0, 4'b1000, 24'd0}) begin
      $display("FAIL rstmid_rerun got %h expected %h", {a0, b0, c0, st0}, {33'd0, 4'b1000, 24'd0});
      n_bad++;
    end
    tick(24);
    n_vec++;
    if (st0 !== {4'b0110, 24'd0}) begin
      $display("FAIL rstmid_pass got %h expected %h", st0, {4'b0110, 24'd0}); n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    fault = 0;
    pulse_start(0);
    tick(4);
    pulse_start(0);
    tick(1);
    n_vec++;
    if ({a0, b0, c0} !== {ta[2], tbv[2], tc[2]}) begin
      $display("FAIL b2b_seq got %h expected %h", {a0, b0, c0}, {ta[2], tbv[2], tc[2]}); n_bad++;
    end
    tick(17);
    pulse_start(0);
    n_vec++;
    if (st0 !== {4'b0110, 24'd0}) begin
      $display("FAIL b2b_finish_start got %h expected %h", st0, {4'b0110, 24'd0}); n_bad++;
    end
    tick(2);
    n_vec++;
    if ({busy0, done0} !== 2'b01) begin
      $display("FAIL b2b_stay_done got %b expected 01", {busy0, done0}); n_bad++;
    end
    pulse_start(0);
    n_vec++;
    if ({a0, b0, c0, busy0, done0, pass0} !== {33'd0, 3'b100}) begin
      $display("FAIL b2b_restart got %h expected %h", {a0, b0, c0, busy0, done0, pass0}, {33'd0, 3'b100});
      n_bad++;
    end
    tick(3);
    n_vec++;
    if ({a0, b0, c0} !== {ta[1], tbv[1], tc[1]}) begin
      $display("FAIL b2b_vec1 got %h expected %h", {a0, b0, c0}, {ta[1], tbv[1], tc[1]}); n_bad++;
    end
  endtask

  initial begin
    ta[0] = 16'h0000; tbv[0] = 16'h0000; tc[0] = 1'b0;
    ta[1] = 16'hFFFF; tbv[1] = 16'h0001; tc[1] = 1'b0;
    ta[2] = 16'hFFFF; tbv[2] = 16'hFFFF; tc[2] = 1'b0;
    ta[3] = 16'hAAAA; tbv[3] = 16'h5555; tc[3] = 1'b1;
    ta[4] = 16'hAAAA; tbv[4] = 16'h5555; tc[4] = 1'b0;
    ta[5] = 16'hFFFF; tbv[5] = 16'h0002; tc[5] = 1'b0;
    ta[6] = 16'h00FF; tbv[6] = 16'h00FF; tc[6] = 1'b1;
    ta[7] = 16'h00FF; tbv[7] = 16'h00FF; tc[7] = 1'b0;
    test_reset();
    test_directed();
    test_ovf_stuck();
    test_saturate();
    test_random();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_bist_ctrl.md
# adder_bist_ctrl

Built-in self-test controller for the 16-bit adder datapath: the stimulus-driving and result-checking end of the adder's `a`/`b`/`carry_in` -> `sum`/`overflow` interface, moved into synthesizable hardware.
- On `start`, it drives 8 fixed directed vectors, then `NUM_RANDOM` LFSR-generated vectors, into the adder.
- It holds each vector for a programmable settle time, then compares the adder's 17-bit result against an internally computed reference.
- It reports an error count, the index of the first failing vector, and pass/done status to the test/debug logic.

## Interface
Parameters:
- NUM_RANDOM, 64: number of pseudo-random vectors after the directed set; 0 is legal; max 65535.
- SETTLE_CYCLES, 2: extra cycles each vector is held before sampling; 0 is legal.
- SEED, 32'hACE1_1234: LFSR load value; must be nonzero.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin a test run; honored only in IDLE or DONE
- sum  in  16  adder sum result
- overflow  in  1  adder carry-out
- a  out  16  operand A to adder
- b  out  16  operand B to adder
- carry_in  out  1  carry-in to adder
- busy  out  1  run in progress
- done  out  1  run complete, held until next start or rst
- pass  out  1  valid when done; 1 iff err_count==0
- err_count  out  8  mismatching vectors, saturates at 255
- first_fail_idx  out  16  index of first mismatching vector
- fail_seen  out  1  at least one mismatch this run

## Operation
States: IDLE, RUN, DONE.
- IDLE/DONE + start -> RUN. On the same edge:
  - load vector 0 onto a/b/carry_in;
  - clear vec_idx, settle_cnt, err_count, fail_seen, first_fail_idx, done and pass;
  - load the LFSR with SEED;
  - set busy.
- RUN: settle_cnt counts 0..SETTLE_CYCLES. On the edge where settle_cnt==SETTLE_CYCLES:
  - Compare {overflow,sum} with ref = {1'b0,a} + {1'b0,b} + carry_in, all 17 bits.
  - On a mismatch:
    - err_count increments, saturating at 255;
    - if fail_seen==0, first_fail_idx<=vec_idx and fail_seen<=1.
  - If vec_idx == 7+NUM_RANDOM (last vector): go to DONE, busy<=0, done<=1, pass<=(no mismatch this run, including this compare). Operands hold their last value.
  - Otherwise: vec_idx++, settle_cnt<=0, load the next vector.
- Directed vectors, in order (a, b, carry_in -> expected overflow:sum):
  - 0: 0000, 0000, 0 -> 0:0000
  - 1: FFFF, 0001, 0 -> 1:0000
  - 2: FFFF, FFFF, 0 -> 1:FFFE
  - 3: AAAA, 5555, 1 -> 1:0000
  - 4: AAAA, 5555, 0 -> 0:FFFF
  - 5: FFFF, 0002, 0 -> 1:0001
  - 6: 00FF, 00FF, 1 -> 0:01FF
  - 7: 00FF, 00FF, 0 -> 0:01FE
- Random vectors (idx >= 8): a=lfsr[15:0], b=lfsr[31:16], carry_in=lfsr[0]^lfsr[31].
  - The LFSR is a 32-bit Fibonacci register, taps 32,22,2,1, shifting left with feedback into bit 0.
  - It advances once per random vector, on the edge that loads that vector; random vector 8 uses SEED advanced once.
- start while in RUN is ignored.
- rst in any state takes effect on the next edge: the run is aborted and all outputs return to reset values.

## Timing
- Reset values: a=0, b=0, carry_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, fail_seen=0; state=IDLE.
- Hold time: each vector is presented for SETTLE_CYCLES+1 cycles; sampling happens at the end of the last of them.
- Run length: with start sampled at edge k, vector n appears after edge k+n*(SETTLE_CYCLES+1), and done rises after edge k+(8+NUM_RANDOM)*(SETTLE_CYCLES+1).
- Defaults: done rises 216 cycles after the start edge.
- Outputs: all outputs are registered; none depend combinationally on sum or overflow.
- Simultaneous events: start and rst together -> rst wins. A start arriving on the same edge the run finishes (in RUN) is ignored.

## Test plan
- Correct behavioural adder, NUM_RANDOM=0, SETTLE_CYCLES=2 -> a/b change every 3 cycles in the directed order; done rises 24 cycles after the start edge; pass=1, err_count=0, fail_seen=0.
- overflow stuck at 0, NUM_RANDOM=0 -> err_count=4 (vectors 1, 2, 3, 5); first_fail_idx=1; fail_seen=1; pass=0.
- sum inverted for every vector, NUM_RANDOM=300 -> err_count saturates at 255 with no wrap; first_fail_idx=0; done after 308*3 cycles.
- Correct adder, defaults -> pass=1 at cycle 216. The bench LFSR model matches a/b/carry_in for all 64 random vectors.
- rst pulsed at vector 5 -> next cycle all outputs are at reset values and state is IDLE. A later start reruns from vector 0 with a cleared err_count.
- start pulsed during RUN -> no effect on the vector sequence. start in DONE -> done/pass clear and a new run begins.
